instruction_fetch_stage: RTL
============================

# instruction_fetch_stage

Instruction fetch stage of the 5-stage MIPS pipeline. Owns the program counter and issues word reads to instruction memory over a request/ready handshake. Feeds the IF/ID pipeline register (which has no enable) with an instruction word and its PC+4 every cycle. Because the IF/ID register has no enable, this stage realises stall, flush and redirect by what it presents: it re-presents the same word to hold IF/ID, or presents a bubble (0x00000000, `sll $0,$0,0`) to flush it.

## Interface
Parameters:
- `RESET_PC`, 32'h0040_0000: first fetch address after reset.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous, active-low reset.
- `stall` in 1: hold request from the hazard unit.
- `branch_taken` in 1: taken branch resolved in ID.
- `branch_target` in 32: branch destination.
- `jump` in 1: j/jal resolved in ID.
- `jump_index` in 26: instruction[25:0] of the jump.
- `id_pcplus4` in 32: PC+4 of the jump instruction.
- `jr` in 1: jump-register resolved in ID.
- `jr_target` in 32: register value for jr.
- `imem_req` out 1: read request.
- `imem_addr` out 32: read address.
- `imem_ready` in 1: read done; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `if_instruction` out 32: word to IF/ID (`instructionIn`).
- `if_pcplus4` out 32: PC+4 to IF/ID.
- `if_valid` out 1: 0 when a bubble is presented.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_addr`: address of the in-flight read; drives `imem_addr`.
  - `buf_instr`, `buf_pc4`: one-entry hold buffer.
  - Output registers for `if_*`.
  - `state`.
- Redirect priority: `jr` > `jump` > `branch_taken`.
  - Jump target = {`id_pcplus4[31:28]`, `jump_index`, 2'b00}.
  - Bits [1:0] of every target are forced to 00.
  - Redirect beats `stall` when both are asserted.
- States:
  - IDLE: reset state.
    - `imem_req`=0.
    - On the first edge with `rst_n`=1, go to FETCH with `req_addr`=`pc`.
  - FETCH: `imem_req`=1, `imem_addr`=`req_addr`.
    - Redirect: load `pc` with the target and present a bubble.
      - If `imem_ready`, discard `imem_rdata`, set `req_addr`=target, stay in FETCH.
      - Otherwise go to DROP.
    - Else if `stall`: hold the outputs unchanged.
      - If `imem_ready`, capture the word into the buffer with `buf_pc4`=`req_addr`+4, set `pc`=`req_addr`+4, go to HOLD.
    - Else if `imem_ready`: present `imem_rdata` with pc4=`req_addr`+4 and valid=1; set `pc` and `req_addr` to `req_addr`+4.
    - Else: present a bubble (valid=0); keep the address stable.
  - HOLD: `imem_req`=0.
    - Redirect: discard the buffer, load `pc` and `req_addr` with the target, present a bubble, go to FETCH.
    - `stall`: hold the outputs.
    - Otherwise: present the buffer with valid=1, set `req_addr`=`pc`, go to FETCH.
  - DROP: `imem_req`=1 with the old `req_addr` until `imem_ready`.
    - Returned data is discarded and a bubble is presented.
    - On `imem_ready`, set `req_addr`=`pc`, go to FETCH.
    - A further redirect while in DROP updates `pc` only.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC + 4 wraps to 0.
- `imem_addr` and `imem_req` never change while a request is pending without `imem_ready`.

## Timing
- Reset values (after an edge with `rst_n`=0):
  - `if_instruction`=0, `if_pcplus4`=0, `if_valid`=0.
  - `imem_req`=0.
  - `pc`=`req_addr`=`RESET_PC`.
  - `state`=IDLE.
  - Buffer cleared.
- First `imem_req` appears in the cycle after the first edge with `rst_n`=1.
- Latency: a word returned with `imem_ready` in cycle N is on `if_*` during cycle N+1 and is captured by IF/ID at the end of N+1.
- Zero-wait memory gives one instruction per cycle.
- A redirect in cycle N puts a bubble on `if_*` in N+1.
  - The request to the target is in N+1 from FETCH/HOLD.
  - From DROP, it is in the cycle after the in-flight `imem_ready`.
- A stall asserted in cycle N freezes `if_*` from N+1 for as long as it stays asserted.
- `rst_n` low mid-request abandons the read: late `imem_ready` is ignored in IDLE.

## Structure
- Shared pipeline package holds:
  - `NOP_INSTR` = 32'h0.
  - The state enum (IDLE/FETCH/HOLD/DROP).
  - The jump-target function.
  - The `RESET_PC` default.
- One sub-module: `pc_redirect_mux`.
  - Combinational priority select plus target formation.
  - Outputs `redirect` and `redirect_pc`.
- The FSM and registers stay in `instruction_fetch_stage`.

## Test plan
- Reset: `rst_n`=0 for 3 cycles, then release.
  - During reset: all outputs 0, `imem_req`=0.
  - Cycle 1 after release: `imem_req`=1, `imem_addr`=0x0040_0000.
- Zero-wait stream: `imem_ready`=1 always, `rdata`=addr^0xA5A5_0000.
  - `if_pcplus4` = 0x0040_0004, 0x0040_0008, 0x0040_000C on consecutive cycles, with matching words and `if_valid`=1.
- Wait states: `imem_ready` asserted 2 cycles after request.
  - Two bubbles (0x0, valid 0) with `imem_addr` held.
  - Then the word appears.
- Stall capture: `stall` high 3 cycles, with `imem_ready` in the first.
  - `if_*` frozen; `imem_req`=0 for stall cycles 2-3.
  - Buffered word presented on the first unstalled cycle.
  - Next `imem_addr` = previous + 4.
- Redirect in flight: `branch_taken` with target 0x0040_0100 while the read of 0x0040_0008 is pending.
  - Word from 0x0040_0008 is discarded and bubbles are presented.
  - Next request is 0x0040_0100.
- Simultaneous `jr`(0x0040_0200) + `branch_taken` + `stall`.
  - Bubble presented.
  - Next fetch address is 0x0040_0200.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the bubble encoding,
// the FSM state codes, the default reset PC and the jump-target helper.
package instruction_fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DROP  = 2'd3;

  // j/jal keep the top nibble of the jump's own PC+4.
  function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                              input logic [25:0] index);
    return {pcplus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_redirect_mux.sv
// Priority select of the redirect source (jr > jump > branch) and formation
// of the word-aligned target address.
module pc_redirect_mux
  import instruction_fetch_stage_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] id_pcplus4,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = branch_target;
    if (jr) begin
      raw_target = jr_target;
    end else if (jump) begin
      raw_target = jump_target(id_pcplus4, jump_index);
    end
  end

  assign redirect    = jr | jump | branch_taken;
  assign redirect_pc = {raw_target[31:2], 2'b00};

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, talks to instruction memory over req/ready and
// drives the enable-less IF/ID register with words, held words or bubbles.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] id_pcplus4,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pcplus4,
  output logic        if_valid,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a read is pending while imem_req=1; it completes in the cycle
  // imem_ready=1 (rdata valid then). imem_req/imem_addr stay constant until then.

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic [31:0]  out_pc4_q, out_pc4_d;
  logic         out_valid_q, out_valid_d;

  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  seq_pc;

  pc_redirect_mux u_redirect (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .id_pcplus4    (id_pcplus4),
    .jr            (jr),
    .jr_target     (jr_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  assign seq_pc = req_addr_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    out_instr_d = out_instr_q;
    out_pc4_d   = out_pc4_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        req_addr_d = pc_q;
      end

      ST_FETCH: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          out_instr_d = NOP_INSTR;
          out_pc4_d   = 32'd0;
          out_valid_d = 1'b0;
          if (imem_ready) begin
            req_addr_d = redirect_pc;
          end else begin
            state_d = ST_DROP;
          end
        end else if (stall) begin
          if (imem_ready) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = seq_pc;
            pc_d        = seq_pc;
            state_d     = ST_HOLD;
          end
        end else if (imem_ready) begin
          out_instr_d = imem_rdata;
          out_pc4_d   = seq_pc;
          out_valid_d = 1'b1;
          pc_d        = seq_pc;
          req_addr_d  = seq_pc;
        end else begin
          out_instr_d = NOP_INSTR;
          out_pc4_d   = 32'd0;
          out_valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d        = redirect_pc;
          req_addr_d  = redirect_pc;
          out_instr_d = NOP_INSTR;
          out_pc4_d   = 32'd0;
          out_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end else if (!stall) begin
          out_instr_d = buf_instr_q;
          out_pc4_d   = buf_pc4_q;
          out_valid_d = 1'b1;
          req_addr_d  = pc_q;
          state_d     = ST_FETCH;
        end
      end

      ST_DROP: begin
        // The abandoned read must still complete before the target is requested.
        out_instr_d = NOP_INSTR;
        out_pc4_d   = 32'd0;
        out_valid_d = 1'b0;
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ready) begin
          req_addr_d = redirect ? redirect_pc : pc_q;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      out_instr_q <= NOP_INSTR;
      out_pc4_q   <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      out_instr_q <= out_instr_d;
      out_pc4_q   <= out_pc4_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign imem_req       = (state_q == ST_FETCH) || (state_q == ST_DROP);
  assign imem_addr      = req_addr_q;
  assign if_instruction = out_instr_q;
  assign if_pcplus4     = out_pc4_q;
  assign if_valid       = out_valid_q;
  assign dbg_state_o    = state_q;

endmodule
